// File: rtl/uart_rx_capture.sv
// UART receiver (8N1) with a 2-flop input synchronizer and a small received-byte FIFO.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_err output.
module uart_rx_capture #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic       PCLK,
    input  logic       PRESET,
    input  logic       tx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun_err,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       busy
);
    localparam int unsigned AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [11:0] HALF_BIT = 12'(CLKS_PER_BIT / 2 - 1);
    localparam logic [11:0] FULL_BIT = 12'(CLKS_PER_BIT - 1);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0] CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef UART_RX_PARITY_EN
        StParity,
`endif
        StStop,
        StWaitHigh
    } state_e;

    logic        sync_q;
    logic        rx_s;
    state_e      state_q;
    logic [11:0] cnt_q;
    logic [2:0]  bit_idx_q;
    logic [7:0]  shift_q;
    logic        expiry;
    logic        push;
`ifdef UART_RX_PARITY_EN
    logic        par_bad_q;
`endif

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            sync_q <= 1'b1;
            rx_s   <= 1'b1;
        end else begin
            sync_q <= tx;
            rx_s   <= sync_q;
        end
    end

    assign expiry = (cnt_q == 12'd0);
    assign busy   = (state_q != StIdle);

`ifdef UART_RX_PARITY_EN
    assign push = (state_q == StStop) && expiry && rx_s && !par_bad_q;
`else
    assign push = (state_q == StStop) && expiry && rx_s;
`endif

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q  <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            case (state_q)
                StIdle: begin
                    if (!rx_s) begin
                        state_q <= StStart;
                        cnt_q   <= HALF_BIT;
                    end
                end
                StStart: begin
                    if (!expiry) begin
                        cnt_q <= cnt_q - 12'd1;
                    end else if (!rx_s) begin
                        state_q   <= StData;
                        cnt_q     <= FULL_BIT;
                        bit_idx_q <= 3'd0;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StData: begin
                    if (!expiry) begin
                        cnt_q <= cnt_q - 12'd1;
                    end else begin
                        shift_q   <= {rx_s, shift_q[7:1]};
                        bit_idx_q <= bit_idx_q + 3'd1;
                        cnt_q     <= FULL_BIT;
                        if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= StParity;
`else
                            state_q <= StStop;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                StParity: begin
                    if (!expiry) begin
                        cnt_q <= cnt_q - 12'd1;
                    end else begin
                        par_bad_q  <= (^shift_q) != rx_s;
                        parity_err <= (^shift_q) != rx_s;
                        cnt_q      <= FULL_BIT;
                        state_q    <= StStop;
                    end
                end
`endif
                StStop: begin
                    if (!expiry) begin
                        cnt_q <= cnt_q - 12'd1;
                    end else if (rx_s) begin
                        state_q <= StIdle;
                    end else begin
                        frame_err <= 1'b1;
                        state_q   <= StWaitHigh;
                    end
                end
                StWaitHigh: begin
                    // Hold off until the line is released so a break cannot look like a start bit.
                    if (rx_s) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          pop;
    logic          full;
    logic          do_push;

    assign rx_valid = (count_q != '0);
    assign pop      = rx_valid && rx_ready;
    assign full     = (count_q == FULL_CNT);
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign do_push  = push && (!full || pop);
    assign rx_data  = rx_valid ? mem[rd_ptr_q] : 8'h00;

    always_ff @(posedge PCLK) begin
        if (do_push && !PRESET) mem[wr_ptr_q] <= shift_q;
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overrun_err <= 1'b0;
        end else begin
            overrun_err <= push && full && !pop;
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)     rd_ptr_q <= rd_ptr_q + PTR_ONE;
            case ({do_push, pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_capture.sv
// Bench for uart_rx_capture at CLKS_PER_BIT=4, FIFO_DEPTH=4: a frame-level model predicts
// every output cycle by cycle, alongside a vector table and directed corner-case sequences.
module tb_uart_rx_capture;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef UART_RX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    // Edges from the cycle the start bit is driven to the edge that samples the stop bit.
    localparam int PUSH_LAT = CPB * (10 + PAR_BITS) + 1;

    logic       PCLK = 1'b0;
    logic       PRESET = 1'b1;
    logic       tx = 1'b1;
    logic       rx_ready = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun_err;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    uart_rx_capture #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .PCLK       (PCLK),
        .PRESET     (PRESET),
        .tx         (tx),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .frame_err  (frame_err),
        .overrun_err(overrun_err),
`ifdef UART_RX_PARITY_EN
        .parity_err (parity_err),
`endif
        .busy       (busy)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        int unsigned at;
        logic [7:0]  d;
        bit          stop_ok;
        bit          par_ok;
    } ev_t;

    typedef struct {
        logic [7:0] d;
        bit         stop_bit;
        bit         exp_push;
        bit         exp_ferr;
    } vec_t;

    int          n_tests = 0;
    int          n_fail = 0;
    int unsigned cyc = 0;
    bit          mon_en = 1'b0;
    bit          ready_rand = 1'b0;
    ev_t         evq[$];
    logic [7:0]  mq[$];
    logic [7:0]  got[$];
    bit          exp_ferr = 1'b0;
    bit          exp_ovr = 1'b0;
    int          ferr_seen = 0;
    int          ovr_seen = 0;
    int          perr_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    always @(posedge PCLK) cyc <= cyc + 1;

    // Model: FIFO contents as a queue; frames become push/error events at a known edge.
    ev_t cur;
    bit  pop_n, psh_n, nf, no, exp_v;
    always @(negedge PCLK) begin
        if (mon_en) begin
            exp_v = (mq.size() != 0);
            check("rx_valid", rx_valid, exp_v);
            check("rx_data", rx_data, exp_v ? mq[0] : 8'h00);
            check("frame_err", frame_err, exp_ferr);
            check("overrun_err", overrun_err, exp_ovr);
            ferr_seen += int'(frame_err);
            ovr_seen  += int'(overrun_err);
`ifdef UART_RX_PARITY_EN
            perr_seen += int'(parity_err);
`endif
            nf = 1'b0;
            no = 1'b0;
            if (PRESET) begin
                mq.delete();
                evq.delete();
            end else begin
                pop_n = exp_v && rx_ready;
                psh_n = 1'b0;
                if (evq.size() != 0 && evq[0].at == cyc + 1) begin
                    cur = evq.pop_front();
                    if (!cur.stop_ok) nf = 1'b1;
                    else if (cur.par_ok) begin
                        if (mq.size() == DEPTH && !pop_n) no = 1'b1;
                        else psh_n = 1'b1;
                    end
                end
                if (pop_n) begin
                    got.push_back(rx_data);
                    mq.delete(0);
                end
                if (psh_n) mq.push_back(cur.d);
            end
            exp_ferr = nf;
            exp_ovr  = no;
        end
    end

    initial forever begin
        @(posedge PCLK);
        #2;
        if (ready_rand) rx_ready = 1'($urandom_range(0, 1));
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge PCLK);
            #2;
        end
    endtask

    task automatic send(input logic [7:0] d, input bit stop_bit, input bit par_flip,
                        input bit release_line, input bit track);
        ev_t e;
        e.at      = cyc + PUSH_LAT;
        e.d       = d;
        e.stop_ok = stop_bit;
        e.par_ok  = !par_flip;
        if (track) evq.push_back(e);
        tx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            tx = d[i];
            tick(CPB);
        end
`ifdef UART_RX_PARITY_EN
        tx = (^d) ^ par_flip;
        tick(CPB);
`endif
        tx = stop_bit;
        tick(CPB);
        if (release_line) tx = 1'b1;
    endtask

    vec_t vecs[6];
    int   g0, f0, o0, p0;
    logic [7:0] rd;
    bit         sb;

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{8'h00, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{8'hFF, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{8'h3C, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{8'h81, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{8'h5A, 1'b0, 1'b0, 1'b1};

        tick(2);
        mon_en = 1'b1;
        tick(1);
        check("reset busy", busy, 1'b0);
        check("reset rx_valid", rx_valid, 1'b0);
        check("reset rx_data", rx_data, 8'h00);
        check("reset frame_err", frame_err, 1'b0);
        check("reset overrun_err", overrun_err, 1'b0);
        PRESET = 1'b0;
        tick(3);

        for (int v = 0; v < 6; v++) begin
            g0 = got.size();
            f0 = ferr_seen;
            send(vecs[v].d, vecs[v].stop_bit, 1'b0, 1'b1, 1'b1);
            tick(6);
            check("vec push count", got.size() - g0, vecs[v].exp_push);
            check("vec byte", (got.size() > g0) ? got[got.size() - 1] : 8'h00,
                  vecs[v].exp_push ? vecs[v].d : 8'h00);
            check("vec frame_err count", ferr_seen - f0, vecs[v].exp_ferr);
            check("vec busy idle", busy, 1'b0);
        end

        // Five bytes into a four-entry FIFO with no consumer.
        rx_ready = 1'b0;
        tick(2);
        o0 = ovr_seen;
        g0 = got.size();
        for (int k = 1; k <= 5; k++) begin
            send(8'(k), 1'b1, 1'b0, 1'b1, 1'b1);
            tick(2);
        end
        tick(4);
        check("overrun pulses", ovr_seen - o0, 1);
        check("full held valid", rx_valid, 1'b1);
        check("full held head", rx_data, 8'h01);
        rx_ready = 1'b1;
        tick(8);
        check("drain count", got.size() - g0, 4);
        for (int j = 0; j < 4; j++) check("drain order", got[g0 + j], 8'(j + 1));

        // Bad stop bit followed by a held-low break.
        g0 = got.size();
        f0 = ferr_seen;
        send(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1);
        tick(20);
        check("break frame_err", ferr_seen - f0, 1);
        check("break busy", busy, 1'b1);
        tx = 1'b1;
        tick(2);
        check("break busy before release seen", busy, 1'b1);
        tick(2);
        for (int j = 0; j < 10; j++) begin
            check("break no restart", busy, 1'b0);
            tick(1);
        end
        check("break no push", got.size() - g0, 0);

        // One-cycle glitch while idle.
        g0 = got.size();
        f0 = ferr_seen;
        o0 = ovr_seen;
        tx = 1'b0;
        tick(1);
        tx = 1'b1;
        tick(2);
        check("glitch start seen", busy, 1'b1);
        tick(3);
        check("glitch aborted", busy, 1'b0);
        tick(6);
        check("glitch no push", got.size() - g0, 0);
        check("glitch no errors", (ferr_seen - f0) + (ovr_seen - o0), 0);

        // Reset during bit 4 of 0xFF, then a clean 0x5A.
        g0 = got.size();
        f0 = ferr_seen;
        tx = 1'b0;
        tick(CPB);
        tx = 1'b1;
        tick(4 * CPB + 2);
        PRESET = 1'b1;
        tick(2);
        check("mid reset busy", busy, 1'b0);
        check("mid reset rx_valid", rx_valid, 1'b0);
        PRESET = 1'b0;
        tick(3);
        check("after reset busy", busy, 1'b0);
        send(8'h5A, 1'b1, 1'b0, 1'b1, 1'b1);
        tick(6);
        check("reset then 5A count", got.size() - g0, 1);
        check("reset then 5A byte", (got.size() > g0) ? got[got.size() - 1] : 8'h00, 8'h5A);
        check("reset no frame_err", ferr_seen - f0, 0);

`ifdef UART_RX_PARITY_EN
        g0 = got.size();
        p0 = perr_seen;
        send(8'h07, 1'b1, 1'b1, 1'b1, 1'b1);
        tick(6);
        check("parity bad pulse", perr_seen - p0, 1);
        check("parity bad no push", got.size() - g0, 0);
        send(8'h07, 1'b1, 1'b0, 1'b1, 1'b1);
        tick(6);
        check("parity good no pulse", perr_seen - p0, 1);
        check("parity good byte", (got.size() > g0) ? got[got.size() - 1] : 8'h00, 8'h07);
`else
        p0 = perr_seen;
`endif

        // Random bytes, random consumer, occasional bad stop bits.
        ready_rand = 1'b1;
        for (int i = 0; i < 40; i++) begin
            rd = 8'($urandom);
            sb = ($urandom_range(0, 7) != 0);
            send(rd, sb, 1'b0, 1'b1, 1'b1);
            tick(sb ? $urandom_range(0, 5) : $urandom_range(4, 8));
        end
        ready_rand = 1'b0;
        rx_ready = 1'b1;
        tick(60);
        check("random drained", rx_valid, 1'b0);
        check("random events consumed", evq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
